// File: rtl/dewhiten_deframer.sv
// PHR/payload deframer with PN9 dewhitening of the payload; bit 0 of every beat is earliest in time.
// Optional macro DEWHITEN_DW_SELECT_EN: dewhiten the payload only when the PHR DW flag (bit 3) is set.
module dewhiten_deframer #(
  parameter int         IN_W      = 1,
  parameter int         PHR_BYTES = 2,
  parameter int         LEN_W     = 11,
  parameter int         MAX_LEN   = 2047,
  parameter logic [8:0] PN9_SEED  = 9'h1FF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_phr,
  output logic             out_sof,
  output logic             out_eof,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_err,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int             PW       = PHR_BYTES * 8;
  localparam int             PCW      = $clog2(PHR_BYTES + 1);
  localparam logic [3:0]     STEP     = 4'(IN_W);
  localparam logic [PCW-1:0] LAST_PHR = PCW'(PHR_BYTES - 1);
  localparam logic [LEN_W:0] MAX_L    = (LEN_W + 1)'(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PHR = 2'd1, S_PAY = 2'd2} state_t;

  // Handshake: a beat transfers when in_valid is high (there is no ready); in_sof
  // counts only with in_valid. out_valid is a one-cycle strobe with no back-pressure.
  state_t             state;
  logic [PW-1:0]      phr;
  logic [7:0]         sr;
  logic [3:0]         bcnt;
  logic [PCW-1:0]     pcnt;
  logic [LEN_W-1:0]   byte_cnt;
  logic [8:0]         pn;
  logic               dw_en;

  logic               start, in_phr, in_pay, byte_done, phr_done, len_bad;
  logic [3:0]         cur_bcnt, bcnt_n;
  logic [PCW-1:0]     cur_pcnt;
  logic [8:0]         pn_w;
  logic [IN_W-1:0]    beat_bits;
  logic [IN_W+7:0]    scat;
  logic [7:0]         sr_n;
  logic [PW+IN_W-1:0] pcat;
  logic [PW-1:0]      phr_n;
  logic [LEN_W-1:0]   len_n;

  always_comb begin
    start     = in_valid && in_sof;
    in_phr    = start || (state == S_PHR);
    in_pay    = !start && (state == S_PAY);
    cur_bcnt  = start ? 4'd0 : bcnt;
    cur_pcnt  = start ? '0 : pcnt;
    // Whitening sequence advances once per payload bit, all IN_W steps inside one beat.
    pn_w      = pn;
    beat_bits = in_data;
    for (int i = 0; i < IN_W; i++) begin
      if (in_pay && dw_en) begin
        beat_bits[i] = in_data[i] ^ pn_w[0];
        pn_w         = {pn_w[0] ^ pn_w[5], pn_w[8:1]};
      end
    end
    scat      = {beat_bits, sr};
    sr_n      = scat[IN_W +: 8];
    pcat      = {in_data, phr};
    phr_n     = pcat[IN_W +: PW];
    bcnt_n    = cur_bcnt + STEP;
    byte_done = (bcnt_n == 4'd8);
    phr_done  = in_phr && byte_done && (cur_pcnt == LAST_PHR);
    len_n     = phr_n[PW-1 -: LEN_W];
    len_bad   = (len_n == '0) || ({1'b0, len_n} > MAX_L);
  end

`ifndef DEWHITEN_DW_SELECT_EN
  assign dw_en = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      phr       <= '0;
      sr        <= '0;
      bcnt      <= '0;
      pcnt      <= '0;
      byte_cnt  <= '0;
      pn        <= PN9_SEED;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_phr   <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      frame_len <= '0;
      frame_err <= 1'b0;
`ifdef DEWHITEN_DW_SELECT_EN
      dw_en     <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      out_phr   <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      frame_err <= 1'b0;
      if (in_valid && (start || state != S_IDLE)) begin
        if (start && state != S_IDLE) frame_err <= 1'b1;
        sr   <= sr_n;
        bcnt <= byte_done ? 4'd0 : bcnt_n;
        if (in_phr) begin
          phr   <= phr_n;
          state <= S_PHR;
          pcnt  <= cur_pcnt;
          if (byte_done) begin
            out_valid <= 1'b1;
            out_data  <= sr_n;
            out_phr   <= 1'b1;
            out_sof   <= (cur_pcnt == '0);
            pcnt      <= cur_pcnt + 1'b1;
          end
          if (phr_done) begin
            if (len_bad) begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
            end else begin
              frame_len <= len_n;
              byte_cnt  <= len_n;
              pn        <= PN9_SEED;
`ifdef DEWHITEN_DW_SELECT_EN
              dw_en     <= phr_n[3];
`endif
              state     <= S_PAY;
            end
          end
        end else begin
          pn <= pn_w;
          if (byte_done) begin
            out_valid <= 1'b1;
            out_data  <= sr_n;
            if (byte_cnt == LEN_W'(1)) begin
              out_eof <= 1'b1;
              state   <= S_IDLE;
            end else begin
              byte_cnt <= byte_cnt - 1'b1;
            end
          end
        end
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_dewhiten_deframer.sv
// Directed bench for dewhiten_deframer: a bit-serial instance (IN_W=1) and a byte-wide instance (IN_W=8).
module tb_dewhiten_deframer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [0:0]  in_data1;
  logic        in_valid1, in_sof1;
  logic [7:0]  out_data1;
  logic        out_valid1, out_phr1, out_sof1, out_eof1, frame_err1, busy1;
  logic [10:0] frame_len1;
  logic [1:0]  dbg_state1;

  logic [7:0]  in_data8;
  logic        in_valid8, in_sof8;
  logic [7:0]  out_data8;
  logic        out_valid8, out_phr8, out_sof8, out_eof8, frame_err8, busy8;
  logic [10:0] frame_len8;
  logic [1:0]  dbg_state8;

  dewhiten_deframer #(.IN_W(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1), .in_sof(in_sof1),
    .out_data(out_data1), .out_valid(out_valid1), .out_phr(out_phr1), .out_sof(out_sof1),
    .out_eof(out_eof1), .frame_len(frame_len1), .frame_err(frame_err1), .busy(busy1),
    .dbg_state(dbg_state1)
  );

  dewhiten_deframer #(.IN_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_data(in_data8), .in_valid(in_valid8), .in_sof(in_sof8),
    .out_data(out_data8), .out_valid(out_valid8), .out_phr(out_phr8), .out_sof(out_sof8),
    .out_eof(out_eof8), .frame_len(frame_len8), .frame_err(frame_err8), .busy(busy8),
    .dbg_state(dbg_state8)
  );

  typedef struct packed {
    logic [7:0]  phr0;
    logic [7:0]  phr1;
    logic [1:0]  npay;
    logic [23:0] pay;
    logic [39:0] exp;
    logic        exp_err;
    logic [10:0] exp_len;
  } vec_t;

  vec_t        vecs[6];
  int          n_vec = 0;
  int          n_bad = 0;
  int          err_cnt = 0;
  logic [10:0] exp_q[$];
  logic [10:0] got_q[$];

  // Output word layout: {phr, sof, eof, data}
  always @(negedge clk) begin
    if (out_valid1) got_q.push_back({out_phr1, out_sof1, out_eof1, out_data1});
    if (frame_err1) err_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] p0, input logic [7:0] p1, input logic [1:0] np,
                              input logic [23:0] pay, input logic [39:0] exp,
                              input logic err, input logic [10:0] len);
    vec_t v;
    v.phr0 = p0; v.phr1 = p1; v.npay = np; v.pay = pay;
    v.exp = exp; v.exp_err = err; v.exp_len = len;
    return v;
  endfunction

  function automatic int n_out(input vec_t v);
    return v.exp_err ? 2 : 2 + int'(v.npay);
  endfunction

  function automatic logic [10:0] exp_word(input vec_t v, input int k);
    logic [7:0] d;
    d = v.exp[8*k +: 8];
    return {k < 2, k == 0, !v.exp_err && (k == 1 + int'(v.npay)), d};
  endfunction

  function automatic logic [7:0] in_byte(input vec_t v, input int k);
    if (k == 0) return v.phr0;
    if (k == 1) return v.phr1;
    return v.pay[8*(k-2) +: 8];
  endfunction

  task automatic idle1(input int n);
    in_valid1 = 1'b0;
    in_sof1   = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte1(input logic [7:0] b, input logic sof);
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) == 0) idle1($urandom_range(1, 2));
      in_data1  = b[i];
      in_valid1 = 1'b1;
      in_sof1   = sof && (i == 0);
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      in_sof1   = 1'b0;
    end
  endtask

  task automatic check_frame1(input string name, input int exp_errs, input logic [10:0] exp_len);
    chk($sformatf("%s count", name), got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (k < got_q.size()) chk($sformatf("%s byte%0d", name, k), got_q[k], exp_q[k]);
    chk($sformatf("%s frame_err", name), err_cnt, exp_errs);
    chk($sformatf("%s frame_len", name), frame_len1, exp_len);
    chk($sformatf("%s busy", name), busy1, 1'b0);
    got_q.delete();
    exp_q.delete();
    err_cnt = 0;
  endtask

  task automatic run_vec1(input vec_t v, input int idx);
    send_byte1(v.phr0, 1'b1);
    send_byte1(v.phr1, 1'b0);
    if (!v.exp_err)
      for (int k = 0; k < int'(v.npay); k++) send_byte1(v.pay[8*k +: 8], 1'b0);
    idle1(3);
    for (int k = 0; k < n_out(v); k++) exp_q.push_back(exp_word(v, k));
    check_frame1($sformatf("w1 vec%0d", idx), int'(v.exp_err), v.exp_len);
  endtask

  task automatic run_vec8(input vec_t v, input int idx);
    for (int k = 0; k < n_out(v); k++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("w8 vec%0d gap", idx), out_valid8, 1'b0);
      end
      in_data8  = in_byte(v, k);
      in_valid8 = 1'b1;
      in_sof8   = (k == 0);
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      in_sof8   = 1'b0;
      chk($sformatf("w8 vec%0d byte%0d", idx, k),
          {out_valid8, out_phr8, out_sof8, out_eof8, out_data8}, {1'b1, exp_word(v, k)});
      if (k == n_out(v) - 1) chk($sformatf("w8 vec%0d frame_err", idx), frame_err8, v.exp_err);
    end
    @(posedge clk); #1;
    chk($sformatf("w8 vec%0d frame_len", idx), frame_len8, v.exp_len);
    chk($sformatf("w8 vec%0d busy", idx), busy8, 1'b0);
  endtask

  initial begin
    vecs[0] = mk(8'h48, 8'h00, 2'd2, 24'h000000, 40'h00E1FF0048, 1'b0, 11'd2);
    vecs[1] = mk(8'h48, 8'h00, 2'd2, 24'h00FFFF, 40'h001E000048, 1'b0, 11'd2);
    vecs[2] = mk(8'h08, 8'h00, 2'd0, 24'h000000, 40'h0000000008, 1'b1, 11'd2);
    vecs[3] = mk(8'h28, 8'h00, 2'd1, 24'h00005A, 40'h0000A50028, 1'b0, 11'd1);
    vecs[4] = mk(8'h68, 8'h00, 2'd3, 24'h000000, 40'h1DE1FF0068, 1'b0, 11'd3);
`ifdef DEWHITEN_DW_SELECT_EN
    vecs[5] = mk(8'h40, 8'h00, 2'd2, 24'h000000, 40'h0000000040, 1'b0, 11'd2);
`else
    vecs[5] = mk(8'h40, 8'h00, 2'd2, 24'h000000, 40'h00E1FF0040, 1'b0, 11'd2);
`endif

    rst = 1'b1;
    in_data1 = '0; in_valid1 = 1'b0; in_sof1 = 1'b0;
    in_data8 = '0; in_valid8 = 1'b0; in_sof8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset w1 outputs", {out_data1, out_valid1, out_phr1, out_sof1, out_eof1, frame_err1, busy1}, 14'h0);
    chk("reset w1 frame_len", frame_len1, 11'd0);
    chk("reset w8 outputs", {out_data8, out_valid8, frame_err8, busy8, frame_len8}, 22'h0);
    rst = 1'b0;
    idle1(2);
    got_q.delete();
    err_cnt = 0;

    for (int i = 0; i < 6; i++) run_vec1(vecs[i], i);
    for (int i = 0; i < 6; i++) run_vec8(vecs[i], i);

    // Beats without in_sof while idle are dropped, then a frame is cut after one payload byte.
    for (int i = 0; i < 5; i++) begin
      in_data1 = 1'b1; in_valid1 = 1'b1; in_sof1 = 1'b0;
      @(posedge clk); #1;
    end
    idle1(1);
    send_byte1(8'h48, 1'b1);
    send_byte1(8'h00, 1'b0);
    send_byte1(8'h00, 1'b0);
    send_byte1(8'h28, 1'b1);
    send_byte1(8'h00, 1'b0);
    send_byte1(8'h5A, 1'b0);
    idle1(3);
    exp_q.push_back({3'b110, 8'h48});
    exp_q.push_back({3'b100, 8'h00});
    exp_q.push_back({3'b000, 8'hFF});
    exp_q.push_back({3'b110, 8'h28});
    exp_q.push_back({3'b100, 8'h00});
    exp_q.push_back({3'b001, 8'hA5});
    check_frame1("abort restart", 1, 11'd1);

    // Reset in the middle of a payload byte, with a competing sof beat in the reset cycle.
    send_byte1(8'h68, 1'b1);
    send_byte1(8'h00, 1'b0);
    send_byte1(8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_data1 = 1'b0; in_valid1 = 1'b1; in_sof1 = 1'b0;
      @(posedge clk); #1;
    end
    idle1(2);
    chk("pre-reset busy", busy1, 1'b1);
    rst = 1'b1; in_data1 = 1'b1; in_valid1 = 1'b1; in_sof1 = 1'b1;
    @(posedge clk); #1;
    chk("mid reset outputs", {out_data1, out_valid1, out_phr1, out_sof1, out_eof1, frame_err1, busy1}, 14'h0);
    chk("mid reset frame_len", frame_len1, 11'd0);
    chk("mid reset state", dbg_state1, 2'd0);
    rst = 1'b0;
    idle1(3);
    exp_q.push_back({3'b110, 8'h68});
    exp_q.push_back({3'b100, 8'h00});
    exp_q.push_back({3'b000, 8'hFF});
    check_frame1("reset abort", 0, 11'd0);
    run_vec1(vecs[3], 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
